// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment capture path: active-low segment
// patterns, the two meaningful anode codes and the capture FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [7:0] ANODE_TENS = 8'b11111110;
  localparam logic [7:0] ANODE_ONES = 8'b11111101;

  typedef enum logic [1:0] {
    WAIT_TENS = 2'd0,
    WAIT_ONES = 2'd1,
    EVAL      = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_to_digit.sv
// Combinational decode of an active-low segment pattern back to a BCD digit.
// A blanked digit reads as 0 so leading-zero blanking round-trips cleanly.
module seg7_to_digit
  import seg7_pkg::*;
(
  input  logic [6:0] segment,
  output logic [3:0] digit,
  output logic       valid
);

  always_comb begin
    digit = '0;
    valid = 1'b1;
    case (segment)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: digit = 4'd0;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_score_capture.sv
// Snoops a multiplexed 2-digit seven-segment scan and recovers a stable score.
// Optional SEG_CAPTURE_ERRCNT_EN adds a saturating err_count output.
module seg7_score_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_SCANS   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] anode,
  input  logic [6:0] segment,
  output logic [7:0] score,
  output logic       score_valid,
  output logic       pattern_err,
  output logic       link_lost
`ifdef SEG_CAPTURE_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int unsigned    TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

  state_t           state_q, state_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic [6:0]       cand_q, cand_d;
  logic             cand_ok_q, cand_ok_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       score_q, score_d;
  logic             score_valid_q, score_valid_d;
  logic             pattern_err_q, pattern_err_d;
  logic             link_lost_q, link_lost_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic [3:0] dig;
  logic       dig_ok;
  logic       is_tens, is_ones, recog;
  logic [6:0] pair;
  logic [6:0] cand_n;
  logic [3:0] cnt_n;

  seg7_to_digit u_dec (
    .segment (segment),
    .digit   (dig),
    .valid   (dig_ok)
  );

  always_comb begin
    state_d       = state_q;
    tens_d        = tens_q;
    ones_d        = ones_q;
    cand_d        = cand_q;
    cand_ok_d     = cand_ok_q;
    cnt_d         = cnt_q;
    score_d       = score_q;
    score_valid_d = 1'b0;
    pattern_err_d = 1'b0;
    link_lost_d   = link_lost_q;
    tmo_d         = tmo_q;
    cand_n        = cand_q;
    cnt_n         = cnt_q;

    is_tens = (anode == ANODE_TENS);
    is_ones = (anode == ANODE_ONES);
    recog   = is_tens | is_ones;
    pair    = {tens_q[3:0], 3'b000} + {2'b00, tens_q[3:0], 1'b0} + {3'b000, ones_q};

    case (state_q)
      WAIT_TENS: begin
        if (recog && !dig_ok) begin
          pattern_err_d = 1'b1;
          cnt_d         = '0;
        end else if (is_tens) begin
          tens_d  = dig;
          state_d = WAIT_ONES;
        end
      end
      WAIT_ONES: begin
        if (recog && !dig_ok) begin
          pattern_err_d = 1'b1;
          cnt_d         = '0;
          state_d       = WAIT_TENS;
        end else if (is_tens) begin
          tens_d = dig;
        end else if (is_ones) begin
          ones_d  = dig;
          state_d = EVAL;
        end
      end
      EVAL: begin
        // Samples arriving here are deliberately dropped.
        if (cand_ok_q && (pair == cand_q)) begin
          cand_n = cand_q;
          cnt_n  = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        end else begin
          cand_n = pair;
          cnt_n  = 4'd1;
        end
        cand_d    = cand_n;
        cand_ok_d = 1'b1;
        cnt_d     = cnt_n;
        if ((32'(cnt_n) >= STABLE_SCANS) && ({1'b0, cand_n} != score_q)) begin
          score_d       = {1'b0, cand_n};
          score_valid_d = 1'b1;
        end
        state_d = WAIT_TENS;
      end
      default: state_d = WAIT_TENS;
    endcase

    // Silence on the recognised anode codes overrides any scan in progress.
    if (recog) begin
      tmo_d       = '0;
      link_lost_d = 1'b0;
    end else begin
      if (tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
      if (tmo_d == TMO_MAX) begin
        link_lost_d = 1'b1;
        cnt_d       = '0;
        state_d     = WAIT_TENS;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WAIT_TENS;
      tens_q        <= '0;
      ones_q        <= '0;
      cand_q        <= '0;
      cand_ok_q     <= 1'b0;
      cnt_q         <= '0;
      score_q       <= '0;
      score_valid_q <= 1'b0;
      pattern_err_q <= 1'b0;
      link_lost_q   <= 1'b0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      tens_q        <= tens_d;
      ones_q        <= ones_d;
      cand_q        <= cand_d;
      cand_ok_q     <= cand_ok_d;
      cnt_q         <= cnt_d;
      score_q       <= score_d;
      score_valid_q <= score_valid_d;
      pattern_err_q <= pattern_err_d;
      link_lost_q   <= link_lost_d;
      tmo_q         <= tmo_d;
    end
  end

  assign score       = score_q;
  assign score_valid = score_valid_q;
  assign pattern_err = pattern_err_q;
  assign link_lost   = link_lost_q;

`ifdef SEG_CAPTURE_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (pattern_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: doc/seg7_score_capture.md
Name: seg7_score_capture

Overview:
- Receive-side counterpart of the score display driver.
- Snoops the multiplexed anode/segment lines and decodes the segment patterns back to BCD digits.
- Qualifies each digit pair for stability and reconstructs the 8-bit binary score.
- Used for loopback self-check of the scoreboard path and to feed the score to a second board or logger.

Parameters:
- STABLE_SCANS, 2: consecutive identical complete scans required before a score is accepted (1..15).
- TIMEOUT_CYCLES, 1024: clocks with no recognised anode code before link_lost asserts (≥4).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- anode  input  8  active-low digit select as driven to the display.
- segment  input  7  active-low segments; segment[6]=a … segment[0]=g.
- score  output  8  last accepted score, binary, 0..99.
- score_valid  output  1  one-cycle pulse when score is updated.
- pattern_err  output  1  one-cycle pulse on an undecodable segment pattern.
- link_lost  output  1  level; high while no scan activity has been seen for TIMEOUT_CYCLES.

Behaviour:
- Reset: synchronous, active-high; clock and reset named clk and rst.
- Reset values:
  - score=0, score_valid=0, pattern_err=0, link_lost=0.
  - State=WAIT_TENS, candidate=none, stable count=0, timeout counter=0.
- Inputs are sampled directly each clk. Only two anode codes are meaningful: 8'b11111110 = tens digit; 8'b11111101 = ones digit. Any other anode value is ignored and the timeout counter is not cleared.
- Decode (active-low patterns):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - Blank 1111111 decodes as 0 (leading-zero blanking).
  - Any other pattern is invalid.
- FSM:
  - WAIT_TENS: on the tens code with a valid pattern, latch tens and go to WAIT_ONES. On the ones code, stay.
  - WAIT_ONES: on the ones code with a valid pattern, latch ones and go to EVAL. On the tens code, re-latch tens and stay.
  - EVAL (one cycle): form pair = tens*10+ones, 7-bit, computed as (tens<<3)+(tens<<1)+ones.
    - If pair == candidate: count++, saturating at 15.
    - Else: candidate=pair, count=1.
    - If count (after update) ≥ STABLE_SCANS and candidate != score: score<=candidate and score_valid=1 in the same cycle; the count is held.
    - Return to WAIT_TENS. Samples arriving during EVAL are dropped.
- Latency: score and score_valid update on the 2nd clk edge after the ones sample that completes the qualifying pair.
- Invalid pattern on either recognised anode code: pattern_err pulses, state returns to WAIT_TENS, count=0, candidate is kept. score is unaffected.
- Identical value: re-acceptance of the same value produces no score_valid pulse.
- Timeout: the counter clears on any recognised anode code and otherwise increments, saturating.
  - When it reaches TIMEOUT_CYCLES: link_lost=1, count=0, state=WAIT_TENS.
  - link_lost deasserts on the cycle after the next recognised anode code.
  - score holds its last value.
- Reset mid-scan: aborts the partial pair, with no output pulse in the reset cycle.

Optional Feature:
- Macro SEG_CAPTURE_ERRCNT_EN.
- When defined: adds output err_count[7:0], an 8-bit count of pattern_err pulses. It saturates at 255, resets to 0, and clears only on rst.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package seg7_pkg holds:
  - the ten digit segment constants and the blank constant;
  - the anode codes ANODE_TENS and ANODE_ONES;
  - the FSM state encoding (WAIT_TENS, WAIT_ONES, EVAL).
- One combinational sub-module, seg7_to_digit: segment[6:0] in; digit[3:0] and valid out.

Test Plan:
- Alternate tens code/1001100 and ones code/0010010 every cycle, STABLE_SCANS=2 -> score=42 with a single score_valid pulse, 2 clocks after the 2nd complete pair; no further pulses while 42 is repeated.
- Tens blank (1111111) with ones 0000100 -> score=9 accepted; then switch to 1001111/0000001 -> after 2 pairs, score=10 and one pulse.
- Ones pattern 1111110 mid-stream -> pattern_err pulses once, score unchanged, count restarts; acceptance needs 2 fresh matching pairs (err_count=1 with SEG_CAPTURE_ERRCNT_EN).
- Alternate 42 and 43 on successive pairs -> no score_valid ever; score stays at its prior value.
- Hold anode=8'hFF for TIMEOUT_CYCLES -> link_lost=1 and score held; resume the scan -> link_lost=0 the cycle after the first recognised code.
- Assert rst for 1 cycle between the tens and ones samples -> all outputs 0, the partial pair is discarded, and the next full 2-pair sequence is accepted normally.
